speaker_tone_driver: RTL and testbench
======================================

SPEAKER_TONE_DRIVER -- requirements
Module: speaker_tone_driver

Interface
REQ-001 Parameter TONE_HALF_0, default 12500, half-period in clocks of channel 0 tone (1 kHz at 25 MHz).
REQ-002 Parameter TONE_HALF_1, default 10000, half-period in clocks of channel 1 tone.
REQ-003 Parameter TONE_HALF_2, default 8333, half-period in clocks of channel 2 tone.
REQ-004 Parameter BEEP_ON_CYC, default 2500000, beep audible duration in clocks.
REQ-005 Parameter BEEP_OFF_CYC, default 2500000, silent gap duration in clocks.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 ena  input  1  block enable; low forces idle.
REQ-009 spk_req  input  3  speaker requests from obstacle state machine, nominally one-hot or zero.
REQ-010 spk_out  output  3  square-wave speaker drives, at most one bit toggling.
REQ-011 busy  output  1  high in BEEP_ON or BEEP_OFF.
REQ-012 active_ch  output  2  channel being served (0..2); 3 when idle.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 Request decode SHALL be priority: spk_req[0] over [1] over [2]; multi-hot resolves to lowest set index.
REQ-015 FSM states SHALL be IDLE, BEEP_ON, BEEP_OFF.
REQ-016 IDLE with any spk_req bit set and ena high: next cycle enters BEEP_ON, latches decoded channel into active_ch, clears beep and tone counters.
REQ-017 BEEP_ON: spk_out[active_ch] SHALL start at 1 on the first BEEP_ON cycle and toggle every TONE_HALF_<ch> clocks; other spk_out bits 0.
REQ-018 BEEP_ON SHALL last exactly BEEP_ON_CYC clocks, then BEEP_OFF.
REQ-019 BEEP_OFF: spk_out all 0; lasts exactly BEEP_OFF_CYC clocks.
REQ-020 End of BEEP_OFF: if any spk_req set, re-decode, latch new channel, enter BEEP_ON; else IDLE.
REQ-021 Request change or drop during BEEP_ON or BEEP_OFF SHALL NOT affect the current beep or gap; channel switches only at REQ-020 boundary.
REQ-022 Minimum output for any accepted request: one full beep plus one full gap.
REQ-023 Tone counter SHALL wrap to 0 on toggle; beep counter width SHALL hold max(BEEP_ON_CYC, BEEP_OFF_CYC) without overflow.
REQ-024 ena low in any state: next cycle IDLE, spk_out 0, busy 0, active_ch 3, counters cleared; ena high again restarts from IDLE decode.
REQ-025 busy and active_ch SHALL change in the same cycle as the state register.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) set state IDLE, spk_out 3'b000, busy 0, active_ch 2'd3, all counters 0.
REQ-027 Release of rst_n SHALL take effect on the next rising clk; first possible BEEP_ON is one cycle after a request is seen in IDLE.
REQ-028 Reset asserted mid-beep SHALL abort the beep with no residual output.

Verification (TONE_HALF_0=2, TONE_HALF_1=3, TONE_HALF_2=4, BEEP_ON_CYC=8, BEEP_OFF_CYC=4)
REQ-029 spk_req=001 held -> spk_out[0] pattern 1,1,0,0,1,1,0,0 for 8 cycles, 4 cycles of 0, repeat; active_ch=0, busy=1 throughout.
REQ-030 spk_req=110 -> channel 1 served; spk_out[1] toggles every 3 clocks; spk_out[0], [2] stay 0.
REQ-031 spk_req=100 pulsed for 1 cycle -> one full 8-cycle beep on spk_out[2] (half-period 4), 4-cycle gap, then IDLE, active_ch=3, busy=0.
REQ-032 spk_req switches 001->010 at BEEP_ON cycle 3 -> channel 0 beep completes, gap, then channel 1 beep starts; no mid-beep switch.
REQ-033 rst_n pulled low at BEEP_ON cycle 5, between clock edges -> spk_out=000, busy=0, active_ch=3 before next edge.
REQ-034 ena driven low during BEEP_OFF with spk_req=001 -> IDLE next cycle, outputs 0; ena high again -> BEEP_ON one cycle later.

Source files
------------

// File: rtl/speaker_tone_driver.sv
// rtl/speaker_tone_driver.sv - priority-decoded three-channel beep/gap square-wave speaker driver
module speaker_tone_driver #(
    parameter int TONE_HALF_0  = 12500,
    parameter int TONE_HALF_1  = 10000,
    parameter int TONE_HALF_2  = 8333,
    parameter int BEEP_ON_CYC  = 2500000,
    parameter int BEEP_OFF_CYC = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] spk_req,
    output logic [2:0] spk_out,
    output logic       busy,
    output logic [1:0] active_ch
);

    localparam int MAX_HALF_01 = (TONE_HALF_0 > TONE_HALF_1) ? TONE_HALF_0 : TONE_HALF_1;
    localparam int MAX_HALF    = (MAX_HALF_01 > TONE_HALF_2) ? MAX_HALF_01 : TONE_HALF_2;
    localparam int MAX_BEEP    = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
    localparam int TW          = $clog2(MAX_HALF + 1);
    localparam int BW          = $clog2(MAX_BEEP + 1);

    localparam logic [BW-1:0] ON_LAST  = BW'(BEEP_ON_CYC - 1);
    localparam logic [BW-1:0] OFF_LAST = BW'(BEEP_OFF_CYC - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BEEP_ON  = 2'd1;
    localparam logic [1:0] S_BEEP_OFF = 2'd2;

    logic [1:0]    state;
    logic [BW-1:0] beep_cnt;
    logic [TW-1:0] tone_cnt;
    logic [1:0]    req_ch;
    logic [TW-1:0] half_last;

    function automatic logic [2:0] onehot(input logic [1:0] ch);
        return 3'b001 << ch;
    endfunction

    // Lowest set request index wins.
    always_comb begin
        req_ch = 2'd2;
        if (spk_req[0])
            req_ch = 2'd0;
        else if (spk_req[1])
            req_ch = 2'd1;
    end

    always_comb begin
        half_last = TW'(TONE_HALF_2 - 1);
        if (active_ch == 2'd0)
            half_last = TW'(TONE_HALF_0 - 1);
        else if (active_ch == 2'd1)
            half_last = TW'(TONE_HALF_1 - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            spk_out   <= 3'b000;
            busy      <= 1'b0;
            active_ch <= 2'd3;
            beep_cnt  <= '0;
            tone_cnt  <= '0;
        end else if (!ena) begin
            state     <= S_IDLE;
            spk_out   <= 3'b000;
            busy      <= 1'b0;
            active_ch <= 2'd3;
            beep_cnt  <= '0;
            tone_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|spk_req) begin
                        state     <= S_BEEP_ON;
                        active_ch <= req_ch;
                        busy      <= 1'b1;
                        spk_out   <= onehot(req_ch);
                        beep_cnt  <= '0;
                        tone_cnt  <= '0;
                    end
                end
                S_BEEP_ON: begin
                    if (beep_cnt == ON_LAST) begin
                        state    <= S_BEEP_OFF;
                        spk_out  <= 3'b000;
                        beep_cnt <= '0;
                        tone_cnt <= '0;
                    end else begin
                        beep_cnt <= beep_cnt + 1'b1;
                        if (tone_cnt == half_last) begin
                            tone_cnt <= '0;
                            spk_out  <= spk_out ^ onehot(active_ch);
                        end else begin
                            tone_cnt <= tone_cnt + 1'b1;
                        end
                    end
                end
                S_BEEP_OFF: begin
                    if (beep_cnt == OFF_LAST) begin
                        beep_cnt <= '0;
                        tone_cnt <= '0;
                        // Requests are only re-sampled here, so a channel never switches mid-beep.
                        if (|spk_req) begin
                            state     <= S_BEEP_ON;
                            active_ch <= req_ch;
                            spk_out   <= onehot(req_ch);
                        end else begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            active_ch <= 2'd3;
                        end
                    end else begin
                        beep_cnt <= beep_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    spk_out   <= 3'b000;
                    busy      <= 1'b0;
                    active_ch <= 2'd3;
                    beep_cnt  <= '0;
                    tone_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speaker_tone_driver.sv
// tb/tb_speaker_tone_driver.sv - directed self-checking bench for speaker_tone_driver
module tb_speaker_tone_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] spk_req;
    logic [2:0] spk_out;
    logic       busy;
    logic [1:0] active_ch;

    int n_checks = 0;
    int n_fail   = 0;

    speaker_tone_driver #(
        .TONE_HALF_0 (2),
        .TONE_HALF_1 (3),
        .TONE_HALF_2 (4),
        .BEEP_ON_CYC (8),
        .BEEP_OFF_CYC(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .spk_req  (spk_req),
        .spk_out  (spk_out),
        .busy     (busy),
        .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_out,
                              input logic e_busy, input logic [1:0] e_ch);
        check({tag, ".spk_out"}, 32'(spk_out), 32'(e_out));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".active_ch"}, 32'(active_ch), 32'(e_ch));
    endtask

    // Hand model: beep cycle k (0..7) drives 1 for the first half, 0 for the next, ...; 8..11 is the gap.
    function automatic logic [2:0] exp_out(input int ch, input int half, input int k);
        logic [2:0] bit_sel;
        bit_sel = 3'b001 << ch;
        if (k < 8 && ((k / half) % 2 == 0))
            return bit_sel;
        return 3'b000;
    endfunction

    task automatic beep_span(input string tag, input int ch, input int half,
                             input int first, input int last);
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            check_outs($sformatf("%s[%0d]", tag, k), exp_out(ch, half, k), 1'b1, 2'(ch));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        spk_req = 3'b000;
        ena     = 1'b1;
        @(negedge clk);
        check_outs(tag, 3'b000, 1'b0, 2'd3);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b0;
        spk_req = 3'b000;
        repeat (2) @(negedge clk);
        check_outs("reset", 3'b000, 1'b0, 2'd3);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        check_outs("idle_no_req", 3'b000, 1'b0, 2'd3);

        // Channel 0 held: beep, gap, then a new beep starts
        spk_req = 3'b001;
        beep_span("ch0", 0, 2, 0, 11);
        beep_span("ch0_rpt", 0, 2, 0, 1);
        do_reset("rst_a");

        // Multi-hot 110 resolves to channel 1
        spk_req = 3'b110;
        beep_span("ch1", 1, 3, 0, 11);
        do_reset("rst_b");

        // One-cycle pulse on channel 2 still yields full beep and gap
        spk_req = 3'b100;
        @(negedge clk);
        check_outs("ch2[0]", 3'b100, 1'b1, 2'd2);
        spk_req = 3'b000;
        beep_span("ch2", 2, 4, 1, 11);
        @(negedge clk);
        check_outs("ch2_idle", 3'b000, 1'b0, 2'd3);
        @(negedge clk);
        check_outs("ch2_idle2", 3'b000, 1'b0, 2'd3);

        // Request switches at beep cycle 3: no mid-beep switch
        spk_req = 3'b001;
        beep_span("sw0", 0, 2, 0, 2);
        spk_req = 3'b010;
        beep_span("sw0", 0, 2, 3, 11);
        beep_span("sw1", 1, 3, 0, 3);
        do_reset("rst_c");

        // Asynchronous reset between edges at beep cycle 5
        spk_req = 3'b001;
        beep_span("ar", 0, 2, 0, 4);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 3'b000, 1'b0, 2'd3);
        @(negedge clk);
        spk_req = 3'b000;
        rst_n   = 1'b1;
        @(negedge clk);
        check_outs("post_rst", 3'b000, 1'b0, 2'd3);

        // ena low during the gap
        spk_req = 3'b001;
        beep_span("en", 0, 2, 0, 9);
        ena = 1'b0;
        @(negedge clk);
        check_outs("ena_low", 3'b000, 1'b0, 2'd3);
        @(negedge clk);
        check_outs("ena_low2", 3'b000, 1'b0, 2'd3);
        ena = 1'b1;
        @(negedge clk);
        check_outs("ena_high", 3'b001, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
